// File: rtl/mem_datos_pkg.sv
// Shared constants for the parametrised RV32I data memory: funct3 codes,
// FSM state encoding and the wait-state counter width.
package mem_datos_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_datos_lane.sv
// Combinational byte-lane logic: load extract/extend, store merge, fault check.
// MEM_DATOS_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module mem_datos_lane
    import mem_datos_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_we,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [31:0] o_rdata,
    output logic [31:0] o_wword,
    output logic        o_wen,
    output logic        o_fault
);
    logic        w_half, w_word, w_illegal, w_misalign;
    logic [1:0]  w_lane;
    logic [3:0]  w_be;
    logic [31:0] w_shr, w_shw;

    always_comb begin
        w_half = (i_funct3 == F3_H) || (i_funct3 == F3_HU);
        w_word = (i_funct3 == F3_W);
        case (i_funct3)
            F3_B, F3_H, F3_W: w_illegal = 1'b0;
            F3_BU, F3_HU:     w_illegal = i_we;
            default:          w_illegal = 1'b1;
        endcase
`ifdef MEM_DATOS_MISALIGN_TRAP_EN
        w_misalign = (w_half && i_lane[0]) || (w_word && (i_lane != 2'b00));
`else
        w_misalign = 1'b0;
`endif
        o_fault = w_illegal || w_misalign;
        // Without the trap, misaligned halves/words silently align down
        w_lane  = w_word ? 2'b00 : (w_half ? {i_lane[1], 1'b0} : i_lane);
        w_shr   = i_rword >> {w_lane, 3'b000};
        w_shw   = i_wdata << {w_lane, 3'b000};

        case (i_funct3)
            F3_B:    w_be = 4'b0001 << w_lane;
            F3_H:    w_be = 4'b0011 << w_lane;
            F3_W:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
        if (o_fault || !i_we)
            w_be = 4'b0000;
        o_wen = |w_be;
        for (int i = 0; i < 4; i++)
            o_wword[8*i +: 8] = w_be[i] ? w_shw[8*i +: 8] : i_rword[8*i +: 8];

        case (i_funct3)
            F3_B:    o_rdata = {{24{w_shr[7]}}, w_shr[7:0]};
            F3_H:    o_rdata = {{16{w_shr[15]}}, w_shr[15:0]};
            F3_W:    o_rdata = i_rword;
            F3_BU:   o_rdata = {24'd0, w_shr[7:0]};
            F3_HU:   o_rdata = {16'd0, w_shr[15:0]};
            default: o_rdata = 32'd0;
        endcase
        if (o_fault || i_we)
            o_rdata = 32'd0;
    end

endmodule

// File: rtl/mem_datos_param.sv
// MEM-stage data memory with req/ready handshake and WAIT_STATES delay.
// Optional macro MEM_DATOS_MISALIGN_TRAP_EN (see mem_datos_lane).
module mem_datos_param
    import mem_datos_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0,
    parameter     INIT_FILE   = ""
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Req,
    input  logic        Write_EN,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] Read_Data,
    output logic        Ready,
    output logic        Busy,
    output logic        Fault
);
    localparam int AW = $clog2(DEPTH_WORDS);

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [2:0]        r_f3;
    logic [AW-1:0]     r_idx;
    logic [1:0]        r_lane;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_fault;
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_commit, w_wen, w_fault;
    logic [31:0]       w_rword, w_ldata, w_wword;
    logic              w_unused_addr;

    // Upper address bits wrap away
    assign w_unused_addr = ^ALUResult[31:AW+2];

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (Req) w_next = ST_WAIT;
            ST_WAIT: if (r_cnt == '0) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy  = (r_state != ST_IDLE);
        Ready = (r_state == ST_DONE);
    end

    assign w_commit  = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_rword   = r_mem[r_idx];
    assign Read_Data = r_rdata;
    assign Fault     = r_fault;

    mem_datos_lane u_lane (
        .i_funct3 (r_f3),
        .i_we     (r_we),
        .i_lane   (r_lane),
        .i_wdata  (r_wdata),
        .i_rword  (w_rword),
        .o_rdata  (w_ldata),
        .o_wword  (w_wword),
        .o_wen    (w_wen),
        .o_fault  (w_fault)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_idx   <= '0;
            r_lane  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (Req) begin
                    r_cnt   <= CNT_W'(WAIT_STATES);
                    r_we    <= Write_EN;
                    r_f3    <= Funct3;
                    r_idx   <= ALUResult[AW+1:2];
                    r_lane  <= ALUResult[1:0];
                    r_wdata <= WriteData;
                end
                ST_WAIT: if (w_commit) begin
                    r_rdata <= w_ldata;
                    r_fault <= w_fault;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                ST_DONE: r_fault <= 1'b0;
                default: ;
            endcase
        end
    end

    // Reset on the commit edge must drop the store
    always_ff @(posedge CLK) begin
        if (!RST && w_commit && w_wen)
            r_mem[r_idx] <= w_wword;
    end

endmodule

// File: tb/tb_mem_datos_param.sv
// Bench: two instances (WAIT_STATES 0 and 3) checked each cycle against a byte-array model.
module tb_mem_datos_param;
    localparam int DEPTH = 256;
    localparam int NB    = 4 * DEPTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, req, wen, rdy, bsy, flt;
    logic [1:0][2:0]  fn3;
    logic [1:0][31:0] adr, wdat, rdat;

    mem_datos_param #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u0 (
        .CLK(clk), .RST(rst[0]), .Req(req[0]), .Write_EN(wen[0]), .Funct3(fn3[0]),
        .ALUResult(adr[0]), .WriteData(wdat[0]), .Read_Data(rdat[0]),
        .Ready(rdy[0]), .Busy(bsy[0]), .Fault(flt[0]));

    mem_datos_param #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u3 (
        .CLK(clk), .RST(rst[1]), .Req(req[1]), .Write_EN(wen[1]), .Funct3(fn3[1]),
        .ALUResult(adr[1]), .WriteData(wdat[1]), .Read_Data(rdat[1]),
        .Ready(rdy[1]), .Busy(bsy[1]), .Fault(flt[1]));

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  mbytes [2][NB];
    bit          mwr    [2][NB];
    int          WS     [2] = '{0, 3};
    int          edge_no = 0;
    int          acc_at [2] = '{-100, -100};
    int          busy_end [2] = '{-100, -100};
    int          commit_at [2] = '{-100, -100};
    bit          p_we   [2];
    logic [2:0]  p_f3   [2];
    logic [31:0] p_a    [2], p_wd [2];
    logic [31:0] e_rd   [2] = '{32'd0, 32'd0};
    bit          e_fl   [2] = '{1'b0, 1'b0};
    bit          e_known[2] = '{1'b1, 1'b1};
    bit          eb, er;

    function automatic void model_access(input int d, input bit we_, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] wd,
                                         output logic [31:0] r, output bit f, output bit known);
        int sz, base;
        bit sgn, ill;
        longint val;
        sz = 1; sgn = 0; ill = 0;
        case (f3)
            3'b000: begin sz = 1; sgn = 1; end
            3'b001: begin sz = 2; sgn = 1; end
            3'b010: begin sz = 4; sgn = 0; end
            3'b100: begin sz = 1; ill = we_; end
            3'b101: begin sz = 2; ill = we_; end
            default: ill = 1;
        endcase
        base = int'(a % NB);
        if (base % sz != 0) begin
`ifdef MEM_DATOS_MISALIGN_TRAP_EN
            ill = 1;
`else
            base = base - (base % sz);
`endif
        end
        r = 32'd0; f = ill; known = 1;
        if (!ill) begin
            if (we_) begin
                for (int i = 0; i < sz; i++) begin
                    mbytes[d][base+i] = wd[8*i +: 8];
                    mwr[d][base+i] = 1;
                end
            end else begin
                val = 0;
                for (int i = 0; i < sz; i++) begin
                    val = val + (longint'(mbytes[d][base+i]) << (8*i));
                    known = known && mwr[d][base+i];
                end
                if (sgn && val[8*sz-1]) val = val - (longint'(1) << (8*sz));
                r = val[31:0];
            end
        end
    endfunction

    always @(posedge clk) begin
        edge_no++;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                busy_end[d] = edge_no; commit_at[d] = -100;
                e_rd[d] = 0; e_fl[d] = 0; e_known[d] = 1;
            end else if (edge_no == commit_at[d]) begin
                model_access(d, p_we[d], p_f3[d], p_a[d], p_wd[d], e_rd[d], e_fl[d], e_known[d]);
            end else if (req[d] && edge_no >= busy_end[d] + 1) begin
                p_we[d] = wen[d]; p_f3[d] = fn3[d]; p_a[d] = adr[d]; p_wd[d] = wdat[d];
                acc_at[d] = edge_no;
                commit_at[d] = edge_no + 1 + WS[d];
                busy_end[d] = edge_no + 2 + WS[d];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                eb = (edge_no >= acc_at[d]) && (edge_no < busy_end[d]);
                er = (edge_no == commit_at[d]);
                chk($sformatf("busy%0d", d), 32'(bsy[d]), 32'(eb));
                chk($sformatf("ready%0d", d), 32'(rdy[d]), 32'(er));
                chk($sformatf("fault%0d", d), 32'(flt[d]), 32'(er && e_fl[d]));
                if (e_known[d]) chk($sformatf("rdata%0d", d), rdat[d], e_rd[d]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] rd;
    logic        f;
    int          lat;

    task automatic wait_ready(input int d, output int l);
        l = 1;
        while (!rdy[d] && l < 40) begin
            @(negedge clk);
            l++;
        end
        if (!rdy[d]) begin
            tests++; fails++;
            $display("FAIL ready_timeout dut%0d: got no Ready expected Ready", d);
        end
    endtask

    task automatic acc(input int d, input bit we_, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] r, output logic fo, output int l);
        @(negedge clk);
        req[d] = 1; wen[d] = we_; fn3[d] = f3; adr[d] = a; wdat[d] = wd;
        @(negedge clk);
        req[d] = 0;
        wait_ready(d, l);
        r = rdat[d]; fo = flt[d];
    endtask

    initial begin
        rst = '1; req = '0; wen = '0; fn3 = '0; adr = '0; wdat = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bsy[0]), 0);
        chk("rst_ready", 32'(rdy[0]), 0);
        chk("rst_fault", 32'(flt[0]), 0);
        chk("rst_rdata", rdat[0], 0);
        rst = '0;
        chk_en = 1;

        acc(0, 1, 3'b010, 32'h4, 32'hDEADBEEF, rd, f, lat);
        chk("sw_lat", lat, 2); chk("sw_fault", 32'(f), 0); chk("sw_rdata", rd, 0);
        acc(0, 0, 3'b010, 32'h4, 0, rd, f, lat);
        chk("lw_lat", lat, 2); chk("lw4", rd, 32'hDEADBEEF); chk("lw_fault", 32'(f), 0);
        acc(0, 1, 3'b000, 32'h5, 32'h80, rd, f, lat);
        acc(0, 0, 3'b000, 32'h5, 0, rd, f, lat);   chk("lb5", rd, 32'hFFFFFF80);
        acc(0, 0, 3'b100, 32'h5, 0, rd, f, lat);   chk("lbu5", rd, 32'h00000080);
        acc(0, 0, 3'b010, 32'h4, 0, rd, f, lat);   chk("lw4_sb", rd, 32'hDEAD80EF);
        acc(0, 1, 3'b001, 32'h6, 32'h1234, rd, f, lat);
        acc(0, 0, 3'b001, 32'h6, 0, rd, f, lat);   chk("lh6", rd, 32'h00001234);
        acc(0, 0, 3'b101, 32'h6, 0, rd, f, lat);   chk("lhu6", rd, 32'h00001234);
        acc(0, 0, 3'b010, 32'h4, 0, rd, f, lat);   chk("lw4_sh", rd, 32'h123480EF);
        acc(0, 0, 3'b010, 32'h5, 0, rd, f, lat);
`ifdef MEM_DATOS_MISALIGN_TRAP_EN
        chk("lw5_fault", 32'(f), 1); chk("lw5_rdata", rd, 0);
`else
        chk("lw5_fault", 32'(f), 0); chk("lw5_rdata", rd, 32'h123480EF);
`endif
        acc(0, 1, 3'b011, 32'h4, 32'hFFFFFFFF, rd, f, lat);
        chk("ill_fault", 32'(f), 1); chk("ill_rdata", rd, 0);
        acc(0, 1, 3'b100, 32'h4, 32'hFFFFFFFF, rd, f, lat);
        chk("sbu_fault", 32'(f), 1);
        acc(0, 0, 3'b010, 32'h4, 0, rd, f, lat);   chk("lw4_ill", rd, 32'h123480EF);
        acc(0, 1, 3'b010, 32'h0, 32'hCAFEF00D, rd, f, lat);
        acc(0, 1, 3'b010, 32'h400, 32'h0BADF00D, rd, f, lat);
        acc(0, 0, 3'b010, 32'h0, 0, rd, f, lat);   chk("wrap_lw0", rd, 32'h0BADF00D);

        acc(1, 1, 3'b010, 32'h8, 32'h12345678, rd, f, lat);
        chk("ws3_sw_lat", lat, 5);
        acc(1, 0, 3'b010, 32'h8, 0, rd, f, lat);
        chk("ws3_lw_lat", lat, 5); chk("ws3_lw8", rd, 32'h12345678);
        acc(1, 1, 3'b010, 32'h10, 32'h33333333, rd, f, lat);

        // Second request while busy must be dropped
        @(negedge clk);
        req[1] = 1; wen[1] = 1; fn3[1] = 3'b010; adr[1] = 32'hC; wdat[1] = 32'h11111111;
        @(negedge clk);
        adr[1] = 32'h10; wdat[1] = 32'h22222222;
        @(negedge clk);
        req[1] = 0;
        wait_ready(1, lat);
        chk("busy_req_lat", lat, 4);
        acc(1, 0, 3'b010, 32'h10, 0, rd, f, lat);  chk("ignored_lw10", rd, 32'h33333333);
        acc(1, 0, 3'b010, 32'hC, 0, rd, f, lat);   chk("accepted_lwC", rd, 32'h11111111);

        // Reset lands on the commit edge of a store
        @(negedge clk);
        req[1] = 1; wen[1] = 1; fn3[1] = 3'b010; adr[1] = 32'h8; wdat[1] = 32'hAAAA5555;
        @(negedge clk);
        req[1] = 0;
        repeat (3) @(negedge clk);
        rst[1] = 1;
        @(negedge clk);
        rst[1] = 0;
        chk("rst_mid_busy", 32'(bsy[1]), 0);
        chk("rst_mid_ready", 32'(rdy[1]), 0);
        chk("rst_mid_fault", 32'(flt[1]), 0);
        chk("rst_mid_rdata", rdat[1], 0);
        acc(1, 0, 3'b010, 32'h8, 0, rd, f, lat);   chk("rst_mid_lw8", rd, 32'h12345678);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
